// File: rtl/cpu_int_arbiter.sv
// cpu_int_arbiter: machine external interrupt arbiter with a four-register
// CPU window (PENDING, ENABLE, CLAIM, COMPLETE). Sources are synchronized,
// latched as pending, claimed into service and released by COMPLETE.
// The lowest source ID that is pending, enabled and not in service wins.
module cpu_int_arbiter #(
    parameter int XLEN      = 32,
    parameter int MEI_PORTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEI_PORTS-1:0] irq_src,
    input  logic                 sel,
    input  logic [3:0]           addr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [3:0]           wenable,
    output logic [XLEN-1:0]      rdata,
    output logic                 mei_pending
);

    localparam logic [1:0] REG_PENDING  = 2'd0;
    localparam logic [1:0] REG_ENABLE   = 2'd1;
    localparam logic [1:0] REG_CLAIM    = 2'd2;
    localparam logic [1:0] REG_COMPLETE = 2'd3;

    logic [MEI_PORTS-1:0] sync1, sync2;
    logic [MEI_PORTS-1:0] pending, in_service, enable;
    logic [MEI_PORTS-1:0] eligible, claim_hit, complete_hit;
    logic [MEI_PORTS-1:0] pending_nxt, in_service_nxt;
    logic                 wr_ok, wr_enable, wr_claim, wr_complete;
    logic [4:0]           best_id;

    // Only word offsets are decoded; the byte lanes of addr carry no meaning.
    logic [1:0] unused_addr;
    assign unused_addr = addr[1:0];

    // Partial-word writes are dropped entirely.
    assign wr_ok       = sel && (wenable == 4'b1111);
    assign wr_enable   = wr_ok && (addr[3:2] == REG_ENABLE);
    assign wr_claim    = wr_ok && (addr[3:2] == REG_CLAIM);
    assign wr_complete = wr_ok && (addr[3:2] == REG_COMPLETE);

    // Per-source decode of the written ID; out-of-range IDs match no source.
    // A claim only counts against a source that is actually pending.
    for (genvar i = 0; i < MEI_PORTS; i++) begin : g_src
        assign claim_hit[i]    = wr_claim && (wdata == XLEN'(i + 1)) && pending[i];
        assign complete_hit[i] = wr_complete && (wdata == XLEN'(i + 1));
    end

    assign eligible = pending & enable & ~in_service;

    // Pending latches while idle and sticks until claimed; a claim wins over a
    // same-cycle set. The pre-edge in_service blocks the set on COMPLETE, so a
    // still-asserted source re-pends one edge after release.
    always_comb begin
        pending_nxt    = (pending | (sync2 & ~in_service)) & ~claim_hit;
        in_service_nxt = (in_service | claim_hit) & ~complete_hit;
    end

    // Lowest eligible index wins; scan downward so the lowest assignment sticks.
    always_comb begin
        best_id = '0;
        for (int i = MEI_PORTS - 1; i >= 0; i--) begin
            if (eligible[i]) best_id = 5'(i + 1);
        end
    end

    // Register window read mux; quiet when the window is not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                REG_PENDING:  rdata = XLEN'(pending);
                REG_ENABLE:   rdata = XLEN'(enable);
                REG_CLAIM:    rdata = XLEN'(best_id);
                REG_COMPLETE: rdata = '0;
                default:      rdata = '0;
            endcase
        end
    end

    // Synchronizer, per-source state and the registered CPU request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            pending     <= '0;
            in_service  <= '0;
            enable      <= '0;
            mei_pending <= 1'b0;
        end else begin
            sync1       <= irq_src;
            sync2       <= sync1;
            pending     <= pending_nxt;
            in_service  <= in_service_nxt;
            if (wr_enable) enable <= wdata[MEI_PORTS-1:0];
            mei_pending <= |eligible;
        end
    end

endmodule

// File: tb/tb_cpu_int_arbiter.sv
// Testbench for cpu_int_arbiter: directed scenarios with fixed expectations
// plus a randomized run against a per-source behavioural model.
module tb_cpu_int_arbiter;

    localparam int P = 4;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P-1:0]    irq_src = '0;
    logic            sel = 1'b0;
    logic [3:0]      addr = '0;
    logic [XLEN-1:0] wdata = '0;
    logic [3:0]      wenable = '0;
    logic [XLEN-1:0] rdata;
    logic            mei_pending;

    int vectors = 0;
    int miscompares = 0;

    cpu_int_arbiter #(.XLEN(XLEN), .MEI_PORTS(P)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .sel(sel), .addr(addr),
        .wdata(wdata), .wenable(wenable), .rdata(rdata), .mei_pending(mei_pending)
    );

    always #5 clk = ~clk;

    // Reference model: each source tracked independently as plain flags.
    bit m_s1[P], m_s2[P], m_pend[P], m_ins[P], m_en[P];
    bit m_mei;

    function automatic logic [31:0] mdl_read(input logic s, input logic [3:0] a);
        logic [31:0] v;
        v = 0;
        if (s) begin
            case (a[3:2])
                2'd0: for (int i = 0; i < P; i++) v[i] = m_pend[i];
                2'd1: for (int i = 0; i < P; i++) v[i] = m_en[i];
                2'd2: begin
                    for (int i = 0; i < P; i++)
                        if (v == 0 && m_pend[i] && m_en[i] && !m_ins[i]) v = 32'(i + 1);
                end
                default: v = 0;
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) begin : model
        bit any, we;
        int cn, dn;
        if (!rst_n) begin
            for (int i = 0; i < P; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_pend[i] = 0; m_ins[i] = 0; m_en[i] = 0;
            end
            m_mei = 0;
        end else begin
            we = sel && (wenable == 4'hF);
            any = 0;
            for (int i = 0; i < P; i++) if (m_pend[i] && m_en[i] && !m_ins[i]) any = 1;
            cn = 0; dn = 0;
            if (we && addr[3:2] == 2'd2 && wdata >= 1 && wdata <= P)
                if (m_pend[int'(wdata) - 1]) cn = int'(wdata);
            if (we && addr[3:2] == 2'd3 && wdata >= 1 && wdata <= P) dn = int'(wdata);
            for (int i = 0; i < P; i++) begin
                if (cn == i + 1)                 m_pend[i] = 0;
                else if (!m_pend[i] && m_s2[i] && !m_ins[i]) m_pend[i] = 1;
            end
            if (cn != 0) m_ins[cn - 1] = 1;
            if (dn != 0) m_ins[dn - 1] = 0;
            if (we && addr[3:2] == 2'd1)
                for (int i = 0; i < P; i++) m_en[i] = wdata[i];
            m_mei = any;
            for (int i = 0; i < P; i++) begin
                m_s2[i] = m_s1[i];
                m_s1[i] = irq_src[i];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
        sel = 1'b1; addr = a; wdata = d; wenable = we;
        cyc();
        sel = 1'b0; wenable = 4'h0; wdata = '0;
    endtask

    task automatic rd_sel(input logic [3:0] a);
        sel = 1'b1; addr = a; wenable = 4'h0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq_src = '0; sel = 1'b0; wenable = 4'h0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq_src = '1;
        cyc(); cyc();
        vectors++;
        if (mei_pending !== 1'b0) begin miscompares++; $display("FAIL reset_mei: got %b want 0", mei_pending); end
        for (int r = 0; r < 3; r++) begin
            rd_sel(4'(r * 4));
            vectors++;
            if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_reg%0d: got %0h want 0", r, rdata); end
        end
        irq_src = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        do_reset();
        bus_wr(4'h4, 32'hF, 4'hF);
        irq_src = 4'b0100;
        for (int e = 1; e <= 4; e++) begin
            cyc();
            vectors++;
            if (mei_pending !== (e == 4)) begin
                miscompares++; $display("FAIL latency_edge%0d: got %b want %b", e, mei_pending, e == 4);
            end
        end
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd3) begin miscompares++; $display("FAIL latency_claim: got %0d want 3", rdata); end
    endtask

    task automatic test_claim_order();
        do_reset();
        bus_wr(4'h4, 32'hF, 4'hF);
        irq_src = 4'b1010;
        repeat (4) cyc();
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd2) begin miscompares++; $display("FAIL order_first: got %0d want 2", rdata); end
        bus_wr(4'h8, 32'd2, 4'hF);
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd4) begin miscompares++; $display("FAIL order_second: got %0d want 4", rdata); end
        vectors++;
        if (mei_pending !== 1'b1) begin miscompares++; $display("FAIL order_mei_held: got %b want 1", mei_pending); end
        bus_wr(4'h8, 32'd4, 4'hF);
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL order_none: got %0d want 0", rdata); end
        cyc();
        vectors++;
        if (mei_pending !== 1'b0) begin miscompares++; $display("FAIL order_mei_drop: got %b want 0", mei_pending); end
    endtask

    task automatic test_complete_rearm();
        do_reset();
        bus_wr(4'h4, 32'h1, 4'hF);
        irq_src = 4'b0001;
        repeat (4) cyc();
        bus_wr(4'h8, 32'd1, 4'hF);
        cyc();
        bus_wr(4'hC, 32'd1, 4'hF);
        rd_sel(4'h0);
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL rearm_blocked: got %0h want 0", rdata); end
        cyc();
        rd_sel(4'h0);
        vectors++;
        if (rdata !== 32'd1) begin miscompares++; $display("FAIL rearm_pending: got %0h want 1", rdata); end
        vectors++;
        if (mei_pending !== 1'b0) begin miscompares++; $display("FAIL rearm_mei_early: got %b want 0", mei_pending); end
        cyc();
        vectors++;
        if (mei_pending !== 1'b1) begin miscompares++; $display("FAIL rearm_mei: got %b want 1", mei_pending); end
        irq_src = '0;
    endtask

    task automatic test_disabled();
        do_reset();
        irq_src = 4'b0001;
        repeat (4) cyc();
        rd_sel(4'h0);
        vectors++;
        if (rdata !== 32'd1) begin miscompares++; $display("FAIL dis_pending: got %0h want 1", rdata); end
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL dis_claim: got %0d want 0", rdata); end
        vectors++;
        if (mei_pending !== 1'b0) begin miscompares++; $display("FAIL dis_mei: got %b want 0", mei_pending); end
        bus_wr(4'h4, 32'h1, 4'hF);
        cyc();
        vectors++;
        if (mei_pending !== 1'b1) begin miscompares++; $display("FAIL dis_enable_mei: got %b want 1", mei_pending); end
        irq_src = '0;
    endtask

    task automatic test_illegal();
        do_reset();
        bus_wr(4'h4, 32'hF, 4'hF);
        irq_src = 4'b0011;
        repeat (4) cyc();
        bus_wr(4'h8, 32'd1, 4'hF);
        cyc();
        bus_wr(4'h8, 32'd0, 4'hF);
        bus_wr(4'h8, 32'd5, 4'hF);
        bus_wr(4'hC, 32'd7, 4'hF);
        bus_wr(4'h4, 32'h0, 4'b0011);
        bus_wr(4'h8, 32'd2, 4'b0111);
        bus_wr(4'hC, 32'd1, 4'b1110);
        cyc();
        rd_sel(4'h0);
        vectors++;
        if (rdata !== 32'h2) begin miscompares++; $display("FAIL ill_pending: got %0h want 2", rdata); end
        rd_sel(4'h4);
        vectors++;
        if (rdata !== 32'hF) begin miscompares++; $display("FAIL ill_enable: got %0h want f", rdata); end
        rd_sel(4'h8);
        vectors++;
        if (rdata !== 32'd2) begin miscompares++; $display("FAIL ill_claim: got %0d want 2", rdata); end
        vectors++;
        if (mei_pending !== 1'b1) begin miscompares++; $display("FAIL ill_mei: got %b want 1", mei_pending); end
        irq_src = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_wr(4'h4, 32'hF, 4'hF);
        irq_src = 4'b0011;
        repeat (4) cyc();
        bus_wr(4'h8, 32'd2, 4'hF);
        rst_n = 1'b0; irq_src = '0;
        cyc();
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            rd_sel(4'(r * 4));
            vectors++;
            if (rdata !== 32'd0) begin miscompares++; $display("FAIL midrst_reg%0d: got %0h want 0", r, rdata); end
        end
        vectors++;
        if (mei_pending !== 1'b0) begin miscompares++; $display("FAIL midrst_mei: got %b want 0", mei_pending); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic       s;
        logic [31:0] exp;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            sel = 1'b0; wenable = 4'h0;
            if ($urandom_range(0, 2) == 0) begin
                sel  = 1'b1;
                addr = 4'($urandom_range(0, 3) * 4);
                wdata = (addr == 4'h4) ? $urandom : 32'($urandom_range(0, 6));
                wenable = ($urandom_range(0, 4) != 0) ? 4'hF : 4'($urandom);
            end
            cyc();
            vectors++;
            if (mei_pending !== m_mei) begin
                miscompares++; $display("FAIL rand_mei @%0d: got %b want %b", n, mei_pending, m_mei);
            end
            s = ($urandom_range(0, 5) != 0);
            a = 4'($urandom);
            sel = s; addr = a; wenable = 4'h0;
            #1;
            exp = mdl_read(s, a);
            vectors++;
            if (rdata !== exp) begin
                miscompares++; $display("FAIL rand_rdata @%0d sel=%b addr=%0h: got %0h want %0h", n, s, a, rdata, exp);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_claim_order();
        test_complete_rearm();
        test_disabled();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
